logic_reduce_pipe: RTL
======================

LOGIC_REDUCE_PIPE -- requirements
Module: logic_reduce_pipe

Interface
REQ-001 Parameter WIDTH, default 3, inputs per channel; legal range 2..16.
REQ-002 Parameter CHANNELS, default 4, independent gate channels; legal range 1..32.
REQ-003 Parameter STAGES, default 2, pipeline register depth; legal range 1..4.
REQ-004 Port CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 Port RN  input  1  reset; synchronous, active-low.
REQ-006 Port VDD, VSS  inout  1 each  supply pins; no functional use.
REQ-007 Port IN_VALID  input  1  input beat offered.
REQ-008 Port IN_READY  output  1  input beat accepted when IN_VALID and IN_READY are both high at an edge.
REQ-009 Port A  input  CHANNELS*WIDTH  channel c uses bits [c*WIDTH +: WIDTH].
REQ-010 Port MODE  input  3  gate function, captured with the beat.
REQ-011 Port OUT_VALID  output  1  result beat present.
REQ-012 Port OUT_READY  input  1  result consumed when OUT_VALID and OUT_READY are both high at an edge.
REQ-013 Port Y  output  CHANNELS  per-channel result, bit c for channel c.
REQ-014 Port ERR  output  1  sticky: a reserved MODE was accepted.

Function
REQ-015 MODE encodings SHALL be: 000 AND, 001 OR, 010 NOR, 011 NAND, 100 XOR, 101 XNOR, 110 MAJ (see REQ-027), 111 reserved.
REQ-016 Each channel SHALL reduce its WIDTH bits with the captured MODE; a reserved mode SHALL yield all-zero Y for that beat.
REQ-017 The result SHALL be computed from A/MODE at the accepting edge and registered into stage 1; stages 2..STAGES SHALL shift it forward.
REQ-018 Each stage SHALL hold a valid bit; Y and OUT_VALID SHALL come from stage STAGES registers only (no combinational path from A to Y).
REQ-019 A stage SHALL load when it is empty or its content moves downstream in the same edge; the last stage moves when OUT_READY is high.
REQ-020 IN_READY SHALL equal (stage 1 empty) OR (stage 1 moves this edge); combinational dependence on OUT_READY is permitted.
REQ-021 Latency: a beat accepted at edge k SHALL appear on Y with OUT_VALID high after edge k+STAGES-1, given OUT_READY held high.
REQ-022 Throughput SHALL be one beat per cycle with OUT_READY held high; no bubbles inserted.
REQ-023 With OUT_READY low and all stages full, IN_READY SHALL be low and Y/OUT_VALID SHALL hold stable.
REQ-024 Beats SHALL leave in acceptance order; no beat dropped or duplicated.
REQ-025 ERR SHALL set on the edge a beat with MODE 111 is accepted and hold until reset.

Reset
REQ-026 While RN is low at an edge: all stage valid bits, Y and ERR SHALL clear to 0; IN_READY SHALL be driven 0 while RN is low; beats in flight are discarded; first acceptance possible at the first edge with RN high.

Configuration
REQ-027 Macro LOGIC_REDUCE_PIPE_MAJ_EN: defined -> MODE 110 yields 1 when more than WIDTH/2 (integer division) inputs are 1; undefined -> MODE 110 treated as reserved (Y=0, ERR sets).

Verification
REQ-028 Defaults, OUT_READY=1, MODE=000, channel 0 A=111, channel 1 A=101 -> after 2 edges OUT_VALID=1, Y[0]=1, Y[1]=0.
REQ-029 MODE=010, all A=000, then MODE=100, channel 0 A=110 -> Y=4'b1111, then Y[0]=0, in order, back-to-back.
REQ-030 Fill pipeline with OUT_READY=0 -> IN_READY=0 after STAGES beats, Y stable; raise OUT_READY -> all beats emerge in order, none lost.
REQ-031 Accept MODE=111 -> Y=0 for that beat, ERR=1 and held; RN low for one edge -> ERR=0, OUT_VALID=0.
REQ-032 MAJ_EN defined, WIDTH=3, A=011 -> Y=1; A=001 -> Y=0; macro undefined, same stimulus -> Y=0, ERR=1.
REQ-033 Assert RN low with 2 beats in flight -> OUT_VALID=0 next cycle, no stale beat emerges after release.

Source files
------------

// File: rtl/logic_reduce_pipe.sv
// Per-channel gate reduction (AND/OR/NOR/NAND/XOR/XNOR, optional MAJ) behind a STAGES-deep register pipeline.
// Latency: a beat accepted at edge k is on Y after edge k+STAGES-1; one beat per cycle when OUT_READY stays high.
// Backpressure: OUT_READY low stalls the last stage and ripples back to IN_READY; macro LOGIC_REDUCE_PIPE_MAJ_EN enables MODE 110.
module logic_reduce_pipe #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 4,
    parameter int STAGES   = 2
) (
    input  logic                      CLK,
    input  logic                      RN,
    inout  wire                       VDD,
    inout  wire                       VSS,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [CHANNELS*WIDTH-1:0] A,
    input  logic [2:0]                MODE,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [CHANNELS-1:0]       Y,
    output logic                      ERR
);

    logic                unused_supply;
    logic [CHANNELS-1:0] y_next;
    logic [CHANNELS-1:0] stage_dat [STAGES];
    logic [STAGES-1:0]   stage_vld;
    logic [STAGES-1:0]   stage_open;
    logic                mode_rsvd;
    logic                accept;
    logic                err_q;

    assign unused_supply = &{1'b0, VDD, VSS};

    function automatic logic reduce(input logic [WIDTH-1:0] a, input logic [2:0] mode);
        logic r;
`ifdef LOGIC_REDUCE_PIPE_MAJ_EN
        int ones;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + int'(a[i]);
        end
`endif
        r = 1'b0;
        case (mode)
            3'b000:  r = &a;
            3'b001:  r = |a;
            3'b010:  r = ~|a;
            3'b011:  r = ~&a;
            3'b100:  r = ^a;
            3'b101:  r = ~^a;
`ifdef LOGIC_REDUCE_PIPE_MAJ_EN
            3'b110:  r = (ones > WIDTH / 2);
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        y_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            y_next[c] = reduce(A[c*WIDTH +: WIDTH], MODE);
        end
    end

`ifdef LOGIC_REDUCE_PIPE_MAJ_EN
    assign mode_rsvd = (MODE == 3'b111);
`else
    assign mode_rsvd = (MODE == 3'b111) || (MODE == 3'b110);
`endif

    // A stage can take new content if it is empty or everything below it drains this edge.
    always_comb begin
        logic down_ok;
        stage_open = '0;
        down_ok    = OUT_READY;
        for (int s = STAGES - 1; s >= 0; s--) begin
            down_ok       = ~stage_vld[s] | down_ok;
            stage_open[s] = down_ok;
        end
    end

    assign IN_READY = RN & stage_open[0];
    assign accept   = IN_VALID & IN_READY;

    always_ff @(posedge CLK) begin
        if (!RN) begin
            stage_vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stage_dat[s] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (stage_open[0]) begin
                stage_vld[0] <= IN_VALID;
                if (IN_VALID) begin
                    stage_dat[0] <= y_next;
                end
            end
            for (int s = 1; s < STAGES; s++) begin
                if (stage_open[s]) begin
                    stage_vld[s] <= stage_vld[s-1];
                    if (stage_vld[s-1]) begin
                        stage_dat[s] <= stage_dat[s-1];
                    end
                end
            end
            if (accept && mode_rsvd) begin
                err_q <= 1'b1;
            end
        end
    end

    assign OUT_VALID = stage_vld[STAGES-1];
    assign Y         = stage_dat[STAGES-1];
    assign ERR       = err_q;

endmodule
